// File: rtl/fifo_n.sv
// fifo_n: parametrised synchronous FIFO with enq/deq/first ENA/RDY method handshake.
//
// It is a deeper, wider replacement for a single-entry FIFO. It adds an occupancy count,
// a synchronous flush and an optional pipelined-full mode.
//
// Parameters:
//   WIDTH     data width of enqueue data and head entry
//   DEPTH     number of entries; power of two, >= 2
//   PIPELINED 1: enqueue is also ready while full if a dequeue is strobed this cycle
//   CW        width of the occupancy count, $clog2(DEPTH+1)
//
// Ports (method name in brackets):
//   i_clk             clock, rising edge                        [CLK]
//   i_rst_n           asynchronous active-low reset             [nRST]
//   i_in_enq_ena      enqueue strobe                            [in$enq__ENA]
//   i_in_enq_v        enqueue data                              [in$enq$v]
//   o_in_enq_rdy      enqueue permitted                         [in$enq__RDY]
//   i_out_deq_ena     dequeue strobe                            [out$deq__ENA]
//   o_out_deq_rdy     dequeue permitted                         [out$deq__RDY]
//   o_out_first       head entry, valid while o_out_first_rdy   [out$first]
//   o_out_first_rdy   head valid                                [out$first__RDY]
//   i_ctl_clear_ena   synchronous flush                         [ctl$clear__ENA]
//   o_ctl_clear_rdy   always 1                                  [ctl$clear__RDY]
//   o_count           occupancy, 0..DEPTH                       [count]
module fifo_n #(
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PIPELINED = 0,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_enq_ena,
  input  logic [WIDTH-1:0] i_in_enq_v,
  output logic             o_in_enq_rdy,
  input  logic             i_out_deq_ena,
  output logic             o_out_deq_rdy,
  output logic [WIDTH-1:0] o_out_first,
  output logic             o_out_first_rdy,
  input  logic             i_ctl_clear_ena,
  output logic             o_ctl_clear_rdy,
  output logic [CW-1:0]    o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Storage and state
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rp;
  logic [AW-1:0]    r_wp;
  logic [CW-1:0]    r_count;

  logic [AW-1:0]    w_rp_d;
  logic [AW-1:0]    w_wp_d;
  logic [CW-1:0]    w_count_d;

  logic             w_full;
  logic             w_empty;
  logic             w_enq_rdy;
  logic             w_deq_rdy;
  logic             w_enq;
  logic             w_deq;
  logic             w_wr_en;

  // Status
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);

  // Ready: the pipelined mode lets a dequeue in the same cycle free the slot being written,
  // which is the only combinational input-to-output path.
  assign w_deq_rdy = !w_empty;
  assign w_enq_rdy = (PIPELINED != 0) ? (!w_full || i_out_deq_ena) : !w_full;

  // Strobes without their ready are ignored.
  assign w_enq   = i_in_enq_ena  && w_enq_rdy;
  assign w_deq   = i_out_deq_ena && w_deq_rdy;

  // Clear discards any enqueue issued in the same cycle.
  assign w_wr_en = w_enq && !i_ctl_clear_ena;

  // Next-state: clear has priority over enq/deq.
  always_comb begin
    w_rp_d    = r_rp;
    w_wp_d    = r_wp;
    w_count_d = r_count;
    if (i_ctl_clear_ena) begin
      w_rp_d    = '0;
      w_wp_d    = '0;
      w_count_d = '0;
    end else begin
      if (w_enq) begin
        w_wp_d = r_wp + AW'(1);   // wraps modulo DEPTH (power of two)
      end
      if (w_deq) begin
        w_rp_d = r_rp + AW'(1);
      end
      unique case ({w_enq, w_deq})
        2'b10:   w_count_d = r_count + CW'(1);
        2'b01:   w_count_d = r_count - CW'(1);
        default: w_count_d = r_count;
      endcase
    end
  end

  // Control state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rp    <= '0;
      r_wp    <= '0;
      r_count <= '0;
    end else begin
      r_rp    <= w_rp_d;
      r_wp    <= w_wp_d;
      r_count <= w_count_d;
    end
  end

  // Data array is not reset. When full in pipelined mode, wp == rp, so the write lands
  // in the slot being vacated.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wp] <= i_in_enq_v;
    end
  end

  // Outputs
  assign o_in_enq_rdy    = w_enq_rdy;
  assign o_out_deq_rdy   = w_deq_rdy;
  assign o_out_first_rdy = w_deq_rdy;
  assign o_out_first     = r_mem[r_rp];
  assign o_ctl_clear_rdy = 1'b1;
  assign o_count         = r_count;

endmodule

// File: tb/tb_fifo_n.sv
module tb_fifo_n;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // dut0: PIPELINED=0, dut1: PIPELINED=1
  logic         e0 = 0, d0 = 0, c0 = 0, e1 = 0, d1 = 0, c1 = 0;
  logic [W-1:0] v0 = '0, v1 = '0;
  logic         er0, dr0, fr0, cr0, er1, dr1, fr1, cr1;
  logic [W-1:0] f0, f1;
  logic [2:0]   n0, n1;

  fifo_n #(.WIDTH(W), .DEPTH(4), .PIPELINED(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_enq_ena(e0), .i_in_enq_v(v0), .o_in_enq_rdy(er0),
    .i_out_deq_ena(d0), .o_out_deq_rdy(dr0),
    .o_out_first(f0), .o_out_first_rdy(fr0),
    .i_ctl_clear_ena(c0), .o_ctl_clear_rdy(cr0),
    .o_count(n0)
  );

  fifo_n #(.WIDTH(W), .DEPTH(4), .PIPELINED(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_enq_ena(e1), .i_in_enq_v(v1), .o_in_enq_rdy(er1),
    .i_out_deq_ena(d1), .o_out_deq_rdy(dr1),
    .o_out_first(f1), .o_out_first_rdy(fr1),
    .i_ctl_clear_ena(c1), .o_ctl_clear_rdy(cr1),
    .o_count(n1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int mcnt[2];
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: whenever a DUT presents a head that is being dequeued, compare with the queue.
  always @(negedge clk) begin
    if (rst_n && d0 && dr0 && !c0) begin
      if (q0.size() == 0) chk("head0_unexpected", 32'(f0), 32'hFFFF_FFFF);
      else chk("head0", 32'(f0), 32'(q0.pop_front()));
    end
    if (rst_n && d1 && dr1 && !c1) begin
      if (q1.size() == 0) chk("head1_unexpected", 32'(f1), 32'hFFFF_FFFF);
      else chk("head1", 32'(f1), 32'(q1.pop_front()));
    end
  end

  // One cycle on dut d. Called at posedge+1; returns at posedge+2 of the next cycle.
  task automatic cyc(input int d, input bit enq, input logic [W-1:0] v, input bit deq,
                     input bit clr);
    int m;
    bit ea, da, rdy;
    m  = mcnt[d];
    rdy = (m < 4) || (d == 1 && deq);
    ea = enq && !clr && rdy;
    da = deq && !clr && (m > 0);
    if (d == 0) begin e0 = enq; v0 = v; d0 = deq; c0 = clr; end
    else        begin e1 = enq; v1 = v; d1 = deq; c1 = clr; end
    if (clr) begin
      if (d == 0) q0.delete(); else q1.delete();
    end else if (ea) begin
      if (d == 0) q0.push_back(v); else q1.push_back(v);
    end
    #1;
    chk("enq_rdy_in_cycle", 32'((d == 0) ? er0 : er1), 32'(rdy));
    @(posedge clk);
    #1;
    mcnt[d] = clr ? 0 : m + int'(ea) - int'(da);
    if (d == 0) begin e0 = 0; d0 = 0; c0 = 0; end
    else        begin e1 = 0; d1 = 0; c1 = 0; end
    #1;
    chk("count",     32'((d == 0) ? n0  : n1),  32'(mcnt[d]));
    chk("deq_rdy",   32'((d == 0) ? dr0 : dr1), 32'(mcnt[d] != 0));
    chk("first_rdy", 32'((d == 0) ? fr0 : fr1), 32'(mcnt[d] != 0));
    chk("enq_rdy",   32'((d == 0) ? er0 : er1), 32'(mcnt[d] != 4));
  endtask

  initial begin
    mcnt[0] = 0;
    mcnt[1] = 0;
    // Reset state
    #12;
    chk("rst_count",     32'(n0),  32'd0);
    chk("rst_enq_rdy",   32'(er0), 32'd1);
    chk("rst_deq_rdy",   32'(dr0), 32'd0);
    chk("rst_clear_rdy", 32'(cr0), 32'd1);
    chk("rst_count1",    32'(n1),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill 1..4, then drain in order
    for (int i = 1; i <= 4; i++) cyc(0, 1, W'(i), 0, 0);
    chk("full_first", 32'(f0), 32'h1);
    chk("full_enq_rdy", 32'(er0), 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1, 0);
    chk("drained_first_rdy", 32'(fr0), 32'd0);

    // Wrap-around at count=2
    cyc(0, 1, 8'h20, 0, 0);
    cyc(0, 1, 8'h21, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, W'(8'h22 + i), 1, 0);
    chk("wrap_first", 32'(f0), 32'h2A);
    cyc(0, 0, '0, 1, 0);
    cyc(0, 0, '0, 1, 0);

    // Non-pipelined full: enq refused, deq alone drops to 3
    for (int i = 0; i < 4; i++) cyc(0, 1, W'(8'h31 + i), 0, 0);
    cyc(0, 1, 8'h99, 1, 0);
    chk("np_full_count", 32'(n0), 32'd3);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1, 0);

    // Pipelined full: enq 0xA with deq keeps 4; 0xA emerges after 3 more deqs
    for (int i = 0; i < 4; i++) cyc(1, 1, W'(8'h41 + i), 0, 0);
    cyc(1, 1, 8'h0A, 1, 0);
    chk("p_full_count", 32'(n1), 32'd4);
    for (int i = 0; i < 3; i++) cyc(1, 0, '0, 1, 0);
    chk("p_head_0a", 32'(f1), 32'h0A);
    cyc(1, 0, '0, 1, 0);

    // Clear priority over enq and deq
    for (int i = 0; i < 3; i++) cyc(0, 1, W'(8'h51 + i), 0, 0);
    cyc(0, 1, 8'h5F, 1, 1);
    chk("clr_count", 32'(n0), 32'd0);
    cyc(0, 1, 8'h60, 0, 0);
    chk("clr_first", 32'(f0), 32'h60);
    cyc(0, 0, '0, 1, 0);

    // Async reset mid-stream at count=2, between edges
    cyc(0, 1, 8'h70, 0, 0);
    cyc(0, 1, 8'h71, 0, 0);
    cyc(1, 1, 8'h72, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_count",     32'(n0),  32'd0);
    chk("arst_first_rdy", 32'(fr0), 32'd0);
    chk("arst_deq_rdy",   32'(dr0), 32'd0);
    chk("arst_enq_rdy",   32'(er0), 32'd1);
    chk("arst_clear_rdy", 32'(cr0), 32'd1);
    chk("arst_count1",    32'(n1),  32'd0);
    mcnt[0] = 0;
    mcnt[1] = 0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // First edge after reset accepts an enqueue
    cyc(0, 1, 8'h77, 0, 0);
    chk("post_rst_first", 32'(f0), 32'h77);
    cyc(0, 0, '0, 1, 0);

    #20;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
